// File: rtl/rob_proc_pkg.sv
// Shared constants and types for the processor memory-side datapath.
package rob_proc_pkg;

    // MDR word width
    localparam int MDR_DATA_W = 18;
    // default request address width
    localparam int MEM_ADDR_W = 8;
    // wait-state counter width; holds 0..15
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } mem_resp_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port data RAM: synchronous write, registered read, one enable.
module mem_array #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // registered read port; only a read access updates it, so it holds the last read word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed wait states, then a
// single-cycle array access and a single-cycle response strobe.
module mem_responder
    import rob_proc_pkg::*;
#(
    parameter int DATA_W   = MDR_DATA_W,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,        // active-low, asynchronous
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_MDR_Mem,
    output logic              wr_ack,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_resp_state_t       state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  err_q, err_d;
    logic                  in_range;

    // out-of-range addresses are rejected rather than aliased onto low words
    assign in_range = (32'(req_addr) < 32'(DEPTH));

    // next-state, wait counter and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req_rd ^ req_wr) && in_range) begin
                    addr_d  = req_addr[IDX_W-1:0];
                    wdata_d = req_wdata;
                    is_wr_d = req_wr;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? ACCESS : WAIT;
                end else if (req_rd || req_wr) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and capture registers; reset aborts any request in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
        end
    end

    // the array is touched only in ACCESS, so rejected or aborted requests never reach it
    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst),
        .en    (state_q == ACCESS),
        .we    (is_wr_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    assign busy       = (state_q != IDLE);
    assign wr_MDR_Mem = (state_q == RESP) && !is_wr_q;
    assign wr_ack     = (state_q == RESP) && is_wr_q;
    assign err        = err_q;

endmodule
